reg_xfer_seq: RTL and testbench

- Sequencer that turns a single 16-bit register transaction request into the series of byte-wide ITF bus accesses the indirect register bridge needs.
- For a write, it loads address, write data low and high bytes, then pulses the OPERATION register with ce+we.
- For a read, it loads the address, pulses OPERATION with ce only, waits a programmable settle time, then reads RDATA_0B and RDATA_1B.
- Sits between the host-side command logic (requester) and the bridge's ITF slave port.

---
 rtl/reg_xfer_seq_if.sv | 26 ++
 rtl/reg_xfer_seq.sv | 147 ++++++++++++++
 tb/tb_reg_xfer_seq.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_xfer_seq_if.sv
// Request/response handshake plus the byte-wide ITF bus that reaches the register bridge.
// The slave modport is the sequencer's view; the master modport is the requester/bridge side.
interface reg_xfer_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [7:0]  itf_addr;
  logic [7:0]  itf_wdata;
  logic        itf_wr;
  logic [7:0]  itf_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, itf_rdata,
    output req_ready, rsp_valid, rsp_rdata, busy, itf_addr, itf_wdata, itf_wr
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, itf_rdata,
    input  req_ready, rsp_valid, rsp_rdata, busy, itf_addr, itf_wdata, itf_wr
  );
endinterface

// File: rtl/reg_xfer_seq.sv
// Turns one 16-bit register request into the byte-wide ITF access sequence of the
// indirect register bridge. Every output is registered and reflects the current state.
module reg_xfer_seq #(
  parameter int RD_WAIT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_xfer_seq_if.slave bus
);

  localparam logic [7:0] A_OPERATION = 8'h01;
  localparam logic [7:0] A_ADDR_0B   = 8'h02;
  localparam logic [7:0] A_WDATA_0B  = 8'h03;
  localparam logic [7:0] A_WDATA_1B  = 8'h04;
  localparam logic [7:0] A_RDATA_0B  = 8'h05;
  localparam logic [7:0] A_RDATA_1B  = 8'h06;
  localparam logic [7:0] OP_WRITE    = 8'h03;
  localparam logic [7:0] OP_READ     = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_ADDR,
    S_W_WD0,
    S_W_WD1,
    S_W_OP,
    S_WAIT,
    S_R_RD0,
    S_R_RD1,
    S_DONE
  } state_t;

  state_t      state;
  logic        we_q;
  logic [15:0] wdata_q;
  logic [3:0]  wait_cnt;
  logic [7:0]  rdata_lo;

  // Outputs are assigned on the transition into a state, so the pins carry that state's values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      we_q          <= 1'b0;
      wdata_q       <= 16'h0000;
      wait_cnt      <= 4'd0;
      rdata_lo      <= 8'h00;
      bus.req_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 16'h0000;
      bus.itf_addr  <= 8'h00;
      bus.itf_wdata <= 8'h00;
      bus.itf_wr    <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.itf_addr  <= 8'h00;
      bus.itf_wdata <= 8'h00;
      bus.itf_wr    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q          <= bus.req_we;
            wdata_q       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
            bus.itf_addr  <= A_ADDR_0B;
            bus.itf_wdata <= bus.req_addr;
            bus.itf_wr    <= 1'b1;
            state         <= S_W_ADDR;
          end
        end

        S_W_ADDR: begin
          bus.itf_wr <= 1'b1;
          if (we_q) begin
            bus.itf_addr  <= A_WDATA_0B;
            bus.itf_wdata <= wdata_q[7:0];
            state         <= S_W_WD0;
          end else begin
            bus.itf_addr  <= A_OPERATION;
            bus.itf_wdata <= OP_READ;
            state         <= S_W_OP;
          end
        end

        S_W_WD0: begin
          bus.itf_addr  <= A_WDATA_1B;
          bus.itf_wdata <= wdata_q[15:8];
          bus.itf_wr    <= 1'b1;
          state         <= S_W_WD1;
        end

        S_W_WD1: begin
          bus.itf_addr  <= A_OPERATION;
          bus.itf_wdata <= OP_WRITE;
          bus.itf_wr    <= 1'b1;
          state         <= S_W_OP;
        end

        S_W_OP: begin
          if (we_q) begin
            bus.rsp_valid <= 1'b1;
            state         <= S_DONE;
          end else begin
            wait_cnt <= 4'(RD_WAIT);
            state    <= S_WAIT;
          end
        end

        // The counter is loaded on entry, so WAIT lasts exactly RD_WAIT cycles.
        S_WAIT: begin
          if (wait_cnt == 4'd1) begin
            bus.itf_addr <= A_RDATA_0B;
            state        <= S_R_RD0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_R_RD0: begin
          rdata_lo     <= bus.itf_rdata;
          bus.itf_addr <= A_RDATA_1B;
          state        <= S_R_RD1;
        end

        S_R_RD1: begin
          bus.rsp_rdata <= {bus.itf_rdata, rdata_lo};
          bus.rsp_valid <= 1'b1;
          state         <= S_DONE;
        end

        S_DONE: begin
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end

        default: begin
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Randomized scoreboard bench for reg_xfer_seq: a bridge model answers ITF reads from its own
// register array, while a reference memory and a cycle schedule predict every ITF write and response.
module tb_reg_xfer_seq;

  localparam int RD_WAIT = 2;

  localparam logic [7:0] A_OP  = 8'h01;
  localparam logic [7:0] A_ADR = 8'h02;
  localparam logic [7:0] A_WD0 = 8'h03;
  localparam logic [7:0] A_WD1 = 8'h04;
  localparam logic [7:0] A_RD0 = 8'h05;
  localparam logic [7:0] A_RD1 = 8'h06;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  typedef struct packed {
    logic [15:0] data;
    int          cyc;
  } rsp_t;

  typedef struct packed {
    int from;
    int idle;
  } win_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  bit   run   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  wr_t  wq[$];
  rsp_t rq[$];
  win_t winq[$];
  int   idle_from  = 0;
  logic [15:0] last_rdata = 16'h0000;

  logic [15:0] ref_mem    [256];
  logic [15:0] bridge_mem [256];
  logic [7:0]  br_addr = 8'h00;
  logic [15:0] br_wd   = 16'h0000;
  logic [15:0] br_rd   = 16'h0000;
  logic [7:0]  junk    = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_xfer_seq_if bus ();
  reg_xfer_seq_if bus_w1 ();
  reg_xfer_seq_if bus_w15 ();

  reg_xfer_seq #(.RD_WAIT(RD_WAIT)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  reg_xfer_seq #(.RD_WAIT(1))       u_dut_w1 (.clk(clk), .rst_n(rst_n), .bus(bus_w1));
  reg_xfer_seq #(.RD_WAIT(15))      u_dut_w15 (.clk(clk), .rst_n(rst_n), .bus(bus_w15));

  assign bus.itf_rdata = (bus.itf_addr == A_RD0) ? br_rd[7:0] :
                         (bus.itf_addr == A_RD1) ? br_rd[15:8] : junk;
  assign bus_w1.itf_rdata  = (bus_w1.itf_addr == A_RD0 || bus_w1.itf_addr == A_RD1) ? 8'hFF : junk;
  assign bus_w15.itf_rdata = (bus_w15.itf_addr == A_RD0 || bus_w15.itf_addr == A_RD1) ? 8'hFF : junk;

  // Bridge: ADDR/WDATA registers plus an OPERATION that commits a write or latches read data.
  initial begin : bridge_model
    for (int i = 0; i < 256; i++) begin
      bridge_mem[i] = 16'($urandom);
      ref_mem[i]    = bridge_mem[i];
    end
    bridge_mem[8'h10] = 16'h1234;
    ref_mem[8'h10]    = 16'h1234;
    forever begin
      @(posedge clk);
      junk <= 8'($urandom);
      if (bus.itf_wr) begin
        case (bus.itf_addr)
          A_ADR: br_addr <= bus.itf_wdata;
          A_WD0: br_wd[7:0] <= bus.itf_wdata;
          A_WD1: br_wd[15:8] <= bus.itf_wdata;
          A_OP: begin
            if (bus.itf_wdata == 8'h03) bridge_mem[br_addr] <= br_wd;
            else if (bus.itf_wdata == 8'h02) br_rd <= bridge_mem[br_addr];
          end
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flagFail(input string name, input int detail);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got event, expected none (detail %0d, cycle %0d)", name, detail, cyc);
  endtask

  // Called just after a rising edge; returns once the request has been taken by the DUT.
  task automatic applyStimulus(input logic we, input logic [7:0] a, input logic [15:0] d, input bit hold);
    int acc;
    int lat;
    logic [15:0] exp_d;
    acc = ((cyc > idle_from) ? cyc : idle_from) + 1;
    lat = we ? 4 : 4 + RD_WAIT;
    wq.push_back('{A_ADR, a, acc});
    if (we) begin
      wq.push_back('{A_WD0, d[7:0], acc + 1});
      wq.push_back('{A_WD1, d[15:8], acc + 2});
      wq.push_back('{A_OP, 8'h03, acc + 3});
      ref_mem[a] = d;
      exp_d = last_rdata;
    end else begin
      wq.push_back('{A_OP, 8'h02, acc + 1});
      exp_d = ref_mem[a];
      last_rdata = exp_d;
    end
    rq.push_back('{exp_d, acc + lat});
    winq.push_back('{acc, acc + lat + 1});
    idle_from = acc + lat + 1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (cyc < acc) begin
      @(posedge clk);
      #1;
    end
    if (!hold) begin
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom);
      bus.req_addr  = 8'($urandom);
      bus.req_wdata = 16'($urandom);
    end
  endtask

  task automatic waitIdle();
    while (cyc <= idle_from) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyMidReset();
    applyStimulus(1'b0, 8'h10, 16'h0000, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("rst_itf_wr", bus.itf_wr, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_req_ready", bus.req_ready, 1'b1);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("rst_itf_addr", bus.itf_addr, 8'h00);
    wq.delete();
    rq.delete();
    winq.delete();
    last_rdata = 16'h0000;
    idle_from  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rsp_rdata_after_reset", bus.rsp_rdata, 16'h0000);
    repeat (12) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runWaitCorners();
    int acc;
    int t1 = -1;
    int t15 = -1;
    int n1 = 0;
    int n15 = 0;
    logic [15:0] d1 = 16'h0;
    logic [15:0] d15 = 16'h0;
    checkOutput("w1_ready", bus_w1.req_ready, 1'b1);
    checkOutput("w15_ready", bus_w15.req_ready, 1'b1);
    bus_w1.req_valid = 1'b1;  bus_w1.req_we = 1'b0;  bus_w1.req_addr = 8'hFF;  bus_w1.req_wdata = 16'($urandom);
    bus_w15.req_valid = 1'b1; bus_w15.req_we = 1'b0; bus_w15.req_addr = 8'hFF; bus_w15.req_wdata = 16'($urandom);
    @(posedge clk);
    #1;
    acc = cyc;
    bus_w1.req_valid  = 1'b0;
    bus_w15.req_valid = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (bus_w1.rsp_valid) begin
        n1++;
        if (t1 < 0) begin t1 = cyc; d1 = bus_w1.rsp_rdata; end
      end
      if (bus_w15.rsp_valid) begin
        n15++;
        if (t15 < 0) begin t15 = cyc; d15 = bus_w15.rsp_rdata; end
      end
      @(posedge clk);
      #1;
    end
    checkOutput("w1_latency", 32'(t1 - acc + 1), 32'd6);
    checkOutput("w15_latency", 32'(t15 - acc + 1), 32'd20);
    checkOutput("w1_pulses", 32'(n1), 32'd1);
    checkOutput("w15_pulses", 32'(n15), 32'd1);
    checkOutput("w1_rdata", d1, 16'hFFFF);
    checkOutput("w15_rdata", d15, 16'hFFFF);
  endtask

  wr_t  mon_w;
  rsp_t mon_r;
  logic exp_busy;

  // Monitor: compares busy/ready every cycle and pops expectations whenever the DUT acts.
  always @(negedge clk) begin
    if (run && rst_n) begin
      while (winq.size() > 0 && cyc >= winq[0].idle) void'(winq.pop_front());
      exp_busy = (winq.size() > 0) && (cyc >= winq[0].from);
      checkOutput("busy", bus.busy, exp_busy);
      checkOutput("req_ready", bus.req_ready, !exp_busy);
      if (bus.itf_wr) begin
        if (wq.size() == 0) flagFail("itf_unexpected", int'(bus.itf_addr));
        else begin
          mon_w = wq.pop_front();
          checkOutput("itf_addr", bus.itf_addr, mon_w.addr);
          checkOutput("itf_wdata", bus.itf_wdata, mon_w.data);
          checkOutput("itf_cycle", cyc, mon_w.cyc);
        end
      end
      if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        flagFail("itf_missing", wq[0].cyc);
        void'(wq.pop_front());
      end
      if (bus.rsp_valid) begin
        if (rq.size() == 0) flagFail("rsp_unexpected", int'(bus.rsp_rdata));
        else begin
          mon_r = rq.pop_front();
          checkOutput("rsp_rdata", bus.rsp_rdata, mon_r.data);
          checkOutput("rsp_cycle", cyc, mon_r.cyc);
        end
      end
      if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        flagFail("rsp_missing", rq[0].cyc);
        void'(rq.pop_front());
      end
    end
  end

  initial begin : stimulus
    bit hold;
    bus.req_valid = 1'b0;     bus.req_we = 1'b0;     bus.req_addr = 8'h00;     bus.req_wdata = 16'h0;
    bus_w1.req_valid = 1'b0;  bus_w1.req_we = 1'b0;  bus_w1.req_addr = 8'h00;  bus_w1.req_wdata = 16'h0;
    bus_w15.req_valid = 1'b0; bus_w15.req_we = 1'b0; bus_w15.req_addr = 8'h00; bus_w15.req_wdata = 16'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", bus.req_ready, 1'b1);
    checkOutput("reset_busy", bus.busy, 1'b0);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("reset_rsp_rdata", bus.rsp_rdata, 16'h0000);
    checkOutput("reset_itf_addr", bus.itf_addr, 8'h00);
    checkOutput("reset_itf_wdata", bus.itf_wdata, 8'h00);
    checkOutput("reset_itf_wr", bus.itf_wr, 1'b0);
    rst_n = 1'b1;
    run   = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 8'h3C, 16'hA55A, 1'b0);
    waitIdle();
    applyStimulus(1'b0, 8'h10, 16'h0000, 1'b0);
    waitIdle();

    applyStimulus(1'b1, 8'h20, 16'hBEEF, 1'b1);
    applyStimulus(1'b0, 8'h20, 16'h0000, 1'b0);
    waitIdle();

    applyStimulus(1'b1, 8'hFF, 16'hFFFF, 1'b0);
    applyStimulus(1'b0, 8'hFF, 16'h0000, 1'b0);
    waitIdle();

    for (int i = 0; i < 40; i++) begin
      hold = (i < 39) && ($urandom_range(0, 2) == 0);
      applyStimulus(1'($urandom), 8'($urandom), 16'($urandom), hold);
      if (!hold) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    waitIdle();

    applyMidReset();
    applyStimulus(1'b0, 8'h3C, 16'h0000, 1'b0);
    waitIdle();
    applyStimulus(1'b1, 8'h3C, 16'h1111, 1'b0);
    waitIdle();

    runWaitCorners();

    for (int k = 0; k < 50 && (wq.size() > 0 || rq.size() > 0); k++) begin
      @(posedge clk);
      #1;
    end
    if (wq.size() > 0 || rq.size() > 0) flagFail("drain", wq.size() + rq.size());
    repeat (3) @(posedge clk);
    #1;
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
